bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 7-segment digit decoders. Each output nibble drives one decoder's 4-bit decimal input.
- Used to show MIPS register, PC or ALU values in decimal on the board displays.
- Converts an unsigned WIDTH-bit value into DIGITS BCD nibbles under a start/done handshake.

---
 rtl/bin_to_bcd_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding 7-segment digit decoders.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_input,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_output,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  // Handshake: start is only looked at in IDLE; busy is high from the accepting
  // edge until FINISH, and done pulses for one cycle when bcd_output is updated.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_result;

  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Leading zero nibbles become 4'hF (blank on the decoder); units never blanked.
  always_comb begin
    logic lead;
    w_result = r_scratch;
    lead     = !r_acc;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (r_scratch[4*k +: 4] == 4'd0)) begin
        w_result[4*k +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign w_result = r_scratch;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_acc      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= binary_input;
            r_scratch <= '0;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Bits leaving the top digit mean the value does not fit in DIGITS digits.
          r_scratch <= {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_acc     <= r_acc | w_adj[BCD_W-1];
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FINISH: begin
          r_bcd      <= w_result;
          r_overflow <= r_acc;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign bcd_output = r_bcd;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule
